alu_issue_stage: RTL

//   Operand-fetch / issue / write-back stage wrapped around the combinational 6-bit ALU.

---
 rtl/alu_issue_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Operand-fetch / issue / write-back stage wrapped around an external combinational ALU.
// Sequences one instruction per three cycles (IDLE -> EXEC -> WB) and owns a small
// register file with r0 hardwired to zero, plus the architectural carry/zero flags.
module alu_issue_stage #(
  parameter int WIDTH = 6,
  parameter int NREGS = 4,
  parameter int RAW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ctrl,
  input  logic [RAW-1:0]   in_rd,
  input  logic [RAW-1:0]   in_rs1,
  input  logic [RAW-1:0]   in_rs2,
  input  logic             in_use_imm,
  input  logic [WIDTH-1:0] in_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             wb_valid,
  output logic [RAW-1:0]   wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             flag_carry,
  output logic             flag_zero,
  output logic             busy
);

  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic [RAW-1:0]   rd_lat_q, rd_lat_d;
  logic [RAW-1:0]   wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic             carry_cap_q, carry_cap_d;
  logic             zero_cap_q, zero_cap_d;
  logic             flag_carry_q, flag_carry_d;
  logic             flag_zero_q, flag_zero_d;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] rf_d [NREGS];
  logic [WIDTH-1:0] rs1_val, rs2_val;

  // Register-file read ports; r0 always reads zero regardless of storage.
  always_comb begin
    rs1_val = (in_rs1 == '0) ? '0 : rf_q[in_rs1];
    rs2_val = (in_rs2 == '0) ? '0 : rf_q[in_rs2];
  end

  // Next-state and datapath updates for the three-phase issue sequence.
  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path leaves a signal unassigned
    // and no latch is inferred.
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rd_lat_d     = rd_lat_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    carry_cap_d  = carry_cap_q;
    zero_cap_d   = zero_cap_q;
    flag_carry_d = flag_carry_q;
    flag_zero_d  = flag_zero_q;
    rf_d         = rf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          alu_a_d    = rs1_val;
          alu_b_d    = in_use_imm ? in_imm : rs2_val;
          alu_ctrl_d = in_ctrl;
          rd_lat_d   = in_rd;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        wb_data_d   = alu_out;
        wb_rd_d     = rd_lat_q;
        carry_cap_d = alu_carry;
        zero_cap_d  = alu_zero;
        state_d     = S_WB;
      end
      S_WB: begin
        if (wb_rd_q != '0) rf_d[wb_rd_q] = wb_data_q;
        flag_zero_d = zero_cap_q;
        // Only arithmetic ops define carry; logic ops leave it untouched.
        if (alu_ctrl_q == CTRL_ADD || alu_ctrl_q == CTRL_SUB) flag_carry_d = carry_cap_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; aborts any in-flight op.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      rd_lat_q     <= '0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      carry_cap_q  <= 1'b0;
      zero_cap_q   <= 1'b0;
      flag_carry_q <= 1'b0;
      flag_zero_q  <= 1'b0;
      // NOTE: the register file is architecturally defined as zero after reset,
      // so it is cleared here; with four entries this stays flop-based storage.
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rd_lat_q     <= rd_lat_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      carry_cap_q  <= carry_cap_d;
      zero_cap_q   <= zero_cap_d;
      flag_carry_q <= flag_carry_d;
      flag_zero_q  <= flag_zero_d;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign in_ready   = (state_q == S_IDLE) && !rst;
  assign busy       = (state_q != S_IDLE);
  assign wb_valid   = (state_q == S_WB) && !rst;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign flag_carry = flag_carry_q;
  assign flag_zero  = flag_zero_q;

endmodule
